// File: rtl/pipe_tx_block_framer.sv
// Single-lane 128b/130b transmit framer: splits each scrambled block into PIPE beats,
// flags block starts and inserts the periodic TxDataValid=0 gap cycle.
//
// state  | meaning
// S_OFF  | electrical idle, upstream held off
// S_WAIT | link active, no block on the lane
// S_BEAT | driving beat beat_q of the held block
// S_GAP  | rate-matching cycle with TxDataValid=0
module pipe_tx_block_framer #(
    parameter int MAXPIPEWIDTH = 32
) (
    input  logic                      PCLK,
    input  logic                      reset,
    input  logic                      tx_en,
    input  logic [127:0]              blk_data,
    input  logic [1:0]                blk_sync,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    output logic [MAXPIPEWIDTH-1:0]   TxData,
    output logic                      TxDataValid,
    output logic                      TxStartBlock,
    output logic [1:0]                TxSyncHeader,
    output logic [MAXPIPEWIDTH/8-1:0] TxDataK,
    output logic                      TxElecIdle,
    output logic                      underrun
);

    localparam int BEATS      = 128 / MAXPIPEWIDTH;
    localparam int GAP_BLOCKS = MAXPIPEWIDTH / 2;
    localparam int BCW        = $clog2(BEATS);
    localparam int GCW        = $clog2(GAP_BLOCKS);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [GCW-1:0] LAST_BLK  = GCW'(GAP_BLOCKS - 1);

    typedef enum logic [1:0] {S_OFF, S_WAIT, S_BEAT, S_GAP} state_t;

    state_t                  state_q, state_d;
    logic [BCW-1:0]          beat_q, beat_d, beat_nxt;
    logic [GCW-1:0]          blk_q, blk_d;
    logic [127:0]            hold_q, hold_d;
    logic [MAXPIPEWIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    start_q, start_d;
    logic [1:0]              sync_q, sync_d;
    logic                    idle_q, idle_d;
    logic                    undr_q, undr_d;
    logic                    last_beat;
    logic                    xfer;

    assign last_beat = (state_q == S_BEAT) && (beat_q == LAST_BEAT);

    always_comb begin
        blk_ready = tx_en && ((state_q == S_WAIT) || (state_q == S_GAP) ||
                              (last_beat && (blk_q != LAST_BLK)));
    end

    assign xfer = blk_valid && blk_ready;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        beat_nxt = beat_q + 1'b1;
        blk_d    = blk_q;
        hold_d   = hold_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        start_d  = 1'b0;
        sync_d   = 2'b00;
        idle_d   = 1'b0;
        undr_d   = undr_q;
        if (!tx_en) begin
            // abandon any block in flight; underrun is sticky across idle
            state_d = S_OFF;
            beat_d  = '0;
            blk_d   = '0;
            idle_d  = 1'b1;
        end else begin
            case (state_q)
                S_OFF: state_d = S_WAIT;
                S_BEAT: begin
                    if (!last_beat) begin
                        beat_d  = beat_nxt;
                        valid_d = 1'b1;
                        data_d  = hold_q[MAXPIPEWIDTH*int'(beat_nxt) +: MAXPIPEWIDTH];
                    end else if (blk_q == LAST_BLK) begin
                        blk_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        blk_d = blk_q + 1'b1;
                        if (!xfer) begin
                            state_d = S_WAIT;
                            undr_d  = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (!xfer) begin
                        state_d = S_WAIT;
                        undr_d  = 1'b1;
                    end
                end
                default: ;
            endcase
            // a new block drives beat 0 straight from the input, no bubble
            if (xfer) begin
                state_d = S_BEAT;
                beat_d  = '0;
                hold_d  = blk_data;
                valid_d = 1'b1;
                start_d = 1'b1;
                sync_d  = blk_sync;
                data_d  = blk_data[MAXPIPEWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            state_q <= S_OFF;
            beat_q  <= '0;
            blk_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            sync_q  <= 2'b00;
            idle_q  <= 1'b1;
            undr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            start_q <= start_d;
            sync_q  <= sync_d;
            idle_q  <= idle_d;
            undr_q  <= undr_d;
        end
    end

    assign TxData       = data_q;
    assign TxDataValid  = valid_q;
    assign TxStartBlock = start_q;
    assign TxSyncHeader = sync_q;
    assign TxDataK      = '0;
    assign TxElecIdle   = idle_q;
    assign underrun     = undr_q;

endmodule

// File: tb/tb_pipe_tx_block_framer.sv
// Bench for pipe_tx_block_framer: directed table, continuous-stream arithmetic checks on
// 32- and 8-bit builds, async reset, and a randomized run against a queue-based model.
module tb_pipe_tx_block_framer;

    logic         PCLK = 1'b0;
    logic         reset;
    logic         en, vld;
    logic [127:0] bdata;
    logic [1:0]   bsync;

    logic        r32, v32, s32, i32, u32;
    logic [31:0] d32;
    logic [1:0]  h32;
    logic [3:0]  k32;
    logic        r8, v8, s8, i8, u8;
    logic [7:0]  d8;
    logic [1:0]  h8;
    logic [0:0]  k8;

    int tests = 0;
    int fails = 0;

    pipe_tx_block_framer #(.MAXPIPEWIDTH(32)) dut32 (
        .PCLK(PCLK), .reset(reset), .tx_en(en), .blk_data(bdata), .blk_sync(bsync),
        .blk_valid(vld), .blk_ready(r32), .TxData(d32), .TxDataValid(v32),
        .TxStartBlock(s32), .TxSyncHeader(h32), .TxDataK(k32), .TxElecIdle(i32),
        .underrun(u32));

    pipe_tx_block_framer #(.MAXPIPEWIDTH(8)) dut8 (
        .PCLK(PCLK), .reset(reset), .tx_en(en), .blk_data(bdata), .blk_sync(bsync),
        .blk_valid(vld), .blk_ready(r8), .TxData(d8), .TxDataValid(v8),
        .TxStartBlock(s8), .TxSyncHeader(h8), .TxDataK(k8), .TxElecIdle(i8),
        .underrun(u8));

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        en, vld, e_rdy, e_idle, e_valid, e_start;
        logic [1:0]  e_sync;
        logic [31:0] e_data;
        logic        e_und;
    } vec_t;

    vec_t tbl[8];

    // continuous feed from OFF: output index i follows a period of BEATS*GAP_BLOCKS+1
    task automatic cont_run(input int ncyc, input logic [127:0] cd);
        @(negedge PCLK);
        en = 1'b1; vld = 1'b1; bdata = cd; bsync = 2'b01;
        #1;
        chk("off rdy32", r32, 0);
        chk("off rdy8", r8, 0);
        @(negedge PCLK);
        chk("wait idle32", i32, 0); chk("wait valid32", v32, 0); chk("wait rdy32", r32, 1);
        chk("wait idle8", i8, 0);   chk("wait valid8", v8, 0);   chk("wait rdy8", r8, 1);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge PCLK);
            for (int w = 0; w < 2; w++) begin
                int wd, nb, ng, pos, bt;
                logic gap;
                logic [31:0] ed, mask, ad;
                logic av, as, ar, au, ai;
                logic [1:0] ay;
                wd   = (w == 0) ? 32 : 8;
                nb   = 128 / wd;
                ng   = wd / 2;
                pos  = i % (nb * ng + 1);
                gap  = (pos == nb * ng);
                bt   = pos % nb;
                mask = (wd == 32) ? 32'hffff_ffff : 32'h0000_00ff;
                ed   = 32'(cd >> (wd * bt)) & mask;
                av = (w == 0) ? v32 : v8;
                as = (w == 0) ? s32 : s8;
                ar = (w == 0) ? r32 : r8;
                au = (w == 0) ? u32 : u8;
                ai = (w == 0) ? i32 : i8;
                ay = (w == 0) ? h32 : h8;
                ad = (w == 0) ? d32 : {24'b0, d8};
                chk($sformatf("w%0d i%0d idle", wd, i), ai, 0);
                chk($sformatf("w%0d i%0d underrun", wd, i), au, 0);
                if (gap) begin
                    chk($sformatf("w%0d i%0d gap valid", wd, i), av, 0);
                    chk($sformatf("w%0d i%0d gap start", wd, i), as, 0);
                    chk($sformatf("w%0d i%0d gap sync", wd, i), ay, 0);
                    chk($sformatf("w%0d i%0d gap rdy", wd, i), ar, 1);
                end else begin
                    chk($sformatf("w%0d i%0d valid", wd, i), av, 1);
                    chk($sformatf("w%0d i%0d start", wd, i), as, bt == 0);
                    chk($sformatf("w%0d i%0d sync", wd, i), ay, (bt == 0) ? 2'b01 : 2'b00);
                    chk($sformatf("w%0d i%0d data", wd, i), ad, ed);
                    chk($sformatf("w%0d i%0d rdy", wd, i), ar,
                        (bt == nb - 1) && (pos / nb != ng - 1));
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; vld = 1'b0; bdata = '0; bsync = 2'b00;
        repeat (2) @(negedge PCLK);
        reset = 1'b0;
    endtask

    // reference model for the 32-bit build: what the outputs show this cycle
    logic        m_idle, m_valid, m_start, m_gap, m_und;
    logic [1:0]  m_sync;
    logic [31:0] m_data;
    logic [31:0] m_q[$];
    int          m_done;

    task automatic model_reset();
        m_idle = 1; m_valid = 0; m_start = 0; m_gap = 0; m_und = 0;
        m_sync = 0; m_data = 0; m_done = 0;
        m_q.delete();
    endtask

    function automatic logic model_ready();
        if (!en || m_idle || m_q.size() != 0) return 1'b0;
        if (m_valid && ((m_done + 1) % 16 == 0)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        logic completing;
        if (!en) begin
            m_idle = 1; m_valid = 0; m_start = 0; m_sync = 0; m_gap = 0;
            m_q.delete(); m_done = 0;
        end else if (m_idle) begin
            m_idle = 0; m_valid = 0; m_start = 0; m_sync = 0; m_gap = 0;
        end else if (m_q.size() != 0) begin
            m_data = m_q.pop_front();
            m_valid = 1; m_start = 0; m_sync = 0; m_gap = 0;
        end else begin
            completing = m_valid;
            if (completing) m_done++;
            if (completing && (m_done % 16 == 0)) begin
                m_gap = 1; m_valid = 0; m_start = 0; m_sync = 0;
            end else if (vld) begin
                m_data = bdata[31:0];
                m_q.push_back(bdata[63:32]);
                m_q.push_back(bdata[95:64]);
                m_q.push_back(bdata[127:96]);
                m_valid = 1; m_start = 1; m_sync = bsync; m_gap = 0;
            end else begin
                if (completing || m_gap) m_und = 1;
                m_valid = 0; m_start = 0; m_sync = 0; m_gap = 0;
            end
        end
    endtask

    initial begin
        logic [127:0] seq;
        logic [127:0] cdat;
        for (int n = 0; n < 16; n++) seq[8*n +: 8] = 8'(n);
        //            en vld rdy idle val st sync data          und
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 32'h03020100, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h07060504, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0B0A0908, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0F0E0D0C, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1};

        do_reset();
        chk("reset idle32", i32, 1);
        chk("reset valid32", v32, 0);
        chk("reset data32", d32, 0);
        bsync = 2'b10;
        for (int r = 0; r < 8; r++) begin
            en = tbl[r].en; vld = tbl[r].vld;
            bdata = (r <= 2) ? seq : {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk($sformatf("tbl%0d rdy", r), r32, tbl[r].e_rdy);
            @(posedge PCLK);
            @(negedge PCLK);
            chk($sformatf("tbl%0d idle", r), i32, tbl[r].e_idle);
            chk($sformatf("tbl%0d valid", r), v32, tbl[r].e_valid);
            chk($sformatf("tbl%0d start", r), s32, tbl[r].e_start);
            chk($sformatf("tbl%0d sync", r), h32, tbl[r].e_sync);
            chk($sformatf("tbl%0d underrun", r), u32, tbl[r].e_und);
            chk($sformatf("tbl%0d txdatak", r), k32, 0);
            if (tbl[r].e_valid) chk($sformatf("tbl%0d data", r), d32, tbl[r].e_data);
        end

        do_reset();
        cdat = {$urandom, $urandom, $urandom, $urandom};
        cont_run(162, cdat);

        // drop tx_en while beat 2 of the third 32-bit block is on the lane
        en = 1'b0; vld = 1'b0;
        @(negedge PCLK);
        cont_run(11, cdat);
        en = 1'b0;
        #1;
        chk("drop rdy32", r32, 0);
        chk("drop rdy8", r8, 0);
        @(negedge PCLK);
        chk("drop idle32", i32, 1); chk("drop valid32", v32, 0);
        chk("drop idle8", i8, 1);   chk("drop valid8", v8, 0);
        cdat = {$urandom, $urandom, $urandom, $urandom};
        cont_run(162, cdat);

        vld = 1'b0;
        repeat (10) @(negedge PCLK);
        chk("starve underrun32", u32, 1);
        vld = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("midblk valid32", v32, 1);
        chk("midblk start32", s32, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("areset idle32", i32, 1);  chk("areset valid32", v32, 0);
        chk("areset start32", s32, 0); chk("areset sync32", h32, 0);
        chk("areset data32", d32, 0);  chk("areset underrun32", u32, 0);
        chk("areset rdy32", r32, 0);
        chk("areset idle8", i8, 1);    chk("areset valid8", v8, 0);
        chk("areset underrun8", u8, 0);
        @(negedge PCLK);
        reset = 1'b0; en = 1'b0; vld = 1'b0;
        model_reset();

        for (int c = 0; c < 3000; c++) begin
            chk("rnd idle", i32, m_idle);
            chk("rnd valid", v32, m_valid);
            chk("rnd start", s32, m_start);
            chk("rnd sync", h32, m_sync);
            chk("rnd underrun", u32, m_und);
            if (m_valid || m_gap) chk("rnd data", d32, m_data);
            en    = ($urandom_range(0, 39) != 0);
            vld   = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 100 : 75));
            bdata = {$urandom, $urandom, $urandom, $urandom};
            bsync = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            #1;
            chk("rnd rdy", r32, model_ready());
            model_step();
            @(negedge PCLK);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_tx_block_framer.md
Name: pipe_tx_block_framer

Overview:
- Single-lane 128b/130b transmit framer for Gen3+ rates.
- Sits directly upstream of the PIPE interface on the MAC side: takes whole 128-bit blocks plus their 2-bit sync header from the lane scrambler and drives one lane's PIPE Tx signals.
- Serialises each block over MAXPIPEWIDTH-bit beats and marks block starts.
- Inserts the PIPE-mandated TxDataValid=0 gap cycle that absorbs the 130/128 rate difference.

Parameters:
MAXPIPEWIDTH, 32, per-lane PIPE data width in bits; legal values 8, 16, 32.
BEATS, 128/MAXPIPEWIDTH (derived, localparam), PCLK beats per block: 16, 8 or 4.
GAP_BLOCKS, MAXPIPEWIDTH/2 (derived, localparam), blocks between gap cycles: 4, 8 or 16.

Ports:
PCLK  input  1  PIPE clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
tx_en  input  1  LTSSM enable for Gen3+ transmission; 0 requests electrical idle.
blk_data  input  128  block payload; byte n is bits [8n+7:8n]; byte 0 is transmitted first.
blk_sync  input  2  sync header (2'b01 = ordered set, 2'b10 = data).
blk_valid  input  1  upstream block available.
blk_ready  output  1  framer accepts the block this cycle (combinational from state and tx_en).
TxData  output  MAXPIPEWIDTH  lane data to PIPE.
TxDataValid  output  1  PIPE TxDataValid.
TxStartBlock  output  1  high on the first beat of each block.
TxSyncHeader  output  2  sync header; valid when TxStartBlock=1, otherwise 0.
TxDataK  output  MAXPIPEWIDTH/8  tied to 0 (no K symbols in 128b/130b).
TxElecIdle  output  1  PIPE TxElecIdle.
underrun  output  1  sticky flag: upstream failed to supply a block back-to-back.

Behaviour:
- All Tx outputs are registered; the state names below describe what is on the outputs in that cycle.
- Transfer occurs when blk_valid && blk_ready. beat_cnt and blk_cnt are the internal beat and block counters.
- Reset (asynchronous): state OFF, TxElecIdle=1, TxDataValid=0, TxStartBlock=0, TxSyncHeader=0, TxData=0, TxDataK=0, underrun=0, beat_cnt=0, blk_cnt=0, holding register=0.
- tx_en=0 in any state:
  - blk_ready=0.
  - Next cycle is OFF.
  - Any in-flight block is abandoned, beat_cnt and blk_cnt are cleared, underrun is kept.
- OFF:
  - Outputs: TxElecIdle=1, TxDataValid=0, blk_ready=0.
  - tx_en=1 → WAIT.
- WAIT (link active, no block):
  - Outputs: TxElecIdle=0, TxDataValid=0, TxStartBlock=0, TxData holds its previous value.
  - blk_ready=1. On transfer: the block is loaded into the holding register and the next state is BEAT with k=0.
- BEAT k (k = 0..BEATS-1):
  - Outputs: TxElecIdle=0, TxDataValid=1, TxData = holding[MAXPIPEWIDTH*(k+1)-1 : MAXPIPEWIDTH*k].
  - k=0: TxStartBlock=1 and TxSyncHeader=the captured blk_sync. Otherwise TxStartBlock=0 and TxSyncHeader=0.
  - k<BEATS-1: blk_ready=0, next state BEAT k+1.
  - k=BEATS-1 and blk_cnt==GAP_BLOCKS-1: blk_ready=0, blk_cnt←0, next state GAP.
  - k=BEATS-1 and blk_cnt<GAP_BLOCKS-1: blk_cnt←blk_cnt+1 and blk_ready=1.
    - Transfer → BEAT with k=0; the new block follows with no bubble.
    - No transfer → WAIT and underrun←1.
- GAP (exactly one cycle):
  - Outputs: TxDataValid=0, TxStartBlock=0, TxSyncHeader=0, TxData holds its previous value.
  - blk_ready=1. Transfer → BEAT with k=0; no transfer → WAIT and underrun←1.
- blk_cnt counts only completed blocks since the last OFF.
  - WAIT does not reset blk_cnt.
  - The gap cycle therefore follows every GAP_BLOCKS-th completed block.
- Latency: the block accepted in cycle N presents beat 0 in cycle N+1.
- blk_data and blk_sync are sampled only on transfer; they may change freely at other times.
- underrun clears only on reset. Entry into WAIT from OFF never sets it.

Test Plan:
1. Reset and enable (MAXPIPEWIDTH=32, reset pulse, tx_en=0) → TxElecIdle=1, TxDataValid=0, blk_ready=0. Then tx_en=1 → one cycle later TxElecIdle=0 and blk_ready=1.
2. Single block with blk_data bytes 0x00..0x0F and blk_sync=2'b10 → the next 4 cycles drive TxData 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. The first of these cycles has TxStartBlock=1 and TxSyncHeader=2'b10. Afterwards the block sits in WAIT and underrun=1.
3. Continuous blk_valid=1 for 40 blocks → 64 back-to-back TxDataValid=1 cycles, then exactly 1 TxDataValid=0 cycle. The pattern repeats with gaps after blocks 16 and 32. blk_ready=0 on the last beat of blocks 16 and 32. underrun stays 0.
4. tx_en dropped at beat 2 of a block → the next cycle is TxElecIdle=1 and TxDataValid=0. After tx_en=1 is restored, the first block starts at TxStartBlock=1 with beat 0 and blk_cnt restarts from 0: the gap comes after 16 new blocks.
5. Asynchronous reset asserted mid-block, between PCLK edges → outputs immediately take their reset values, with underrun=0 and TxElecIdle=1.
6. MAXPIPEWIDTH=8 build with continuous blocks → 16 valid beats per block. TxStartBlock=1 every 16 beats. One TxDataValid=0 cycle after every 4 blocks.
